// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared types and constants for the data_ram arbiter
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2
  } arb_state_e;

  localparam logic ARB_MASTER0 = 1'b0;
  localparam logic ARB_MASTER1 = 1'b1;

  localparam int DATA_ADDR_W = 32;
  localparam int DATA_W      = 32;

  localparam logic [3:0] HOLD_SAT = 4'd15;

  function automatic logic [3:0] hold_next(input logic [3:0] cnt);
    return (cnt == HOLD_SAT) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_pick2.sv
// rtl/data_ram_arbiter_rr_pick2.sv - combinational two-way round-robin winner select
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic holder,
  input  logic stay,
  output logic grant,
  output logic valid
);

  always_comb begin
    grant = last;
    valid = 1'b1;
    if (stay) begin
      grant = holder;
    end else if (req0 ^ req1) begin
      grant = req1;
    end else if (req0 && req1) begin
      grant = ~last;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin arbiter with bounded lock sharing data_ram between two masters
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m1_req,
  input  logic                   m0_lock,
  input  logic                   m1_lock,
  input  logic                   m0_we,
  input  logic                   m1_we,
  input  logic [3:0]             m0_sel,
  input  logic [3:0]             m1_sel,
  input  logic [DATA_ADDR_W-1:0] m0_addr,
  input  logic [DATA_ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0]      m0_wdata,
  input  logic [DATA_W-1:0]      m1_wdata,
  output logic [DATA_W-1:0]      m0_rdata,
  output logic [DATA_W-1:0]      m1_rdata,
  output logic                   m0_ack,
  output logic                   m1_ack,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [3:0]             ram_sel,
  output logic [DATA_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]      ram_data_o,
  input  logic [DATA_W-1:0]      ram_data_i
);

  arb_state_e r_state;
  logic       r_last;
  logic [3:0] r_hold_cnt;

  logic w_held, w_holder, w_h_req, w_h_lock, w_o_req;
  logic w_stay, w_grant, w_valid;
  logic w_act0, w_act1;

  assign w_held   = (r_state != ARB_IDLE);
  assign w_holder = (r_state == ARB_G1) ? ARB_MASTER1 : ARB_MASTER0;
  assign w_h_req  = w_holder ? m1_req  : m0_req;
  assign w_h_lock = w_holder ? m1_lock : m0_lock;
  assign w_o_req  = w_holder ? m0_req  : m1_req;

  // Lock is honoured unconditionally when uncontended, otherwise only below MAX_HOLD.
  assign w_stay = w_held && w_h_req && w_h_lock &&
                  (!w_o_req || (r_hold_cnt < 4'(MAX_HOLD)));

  rr_pick2 u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (r_last),
    .holder (w_holder),
    .stay   (w_stay),
    .grant  (w_grant),
    .valid  (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_last     <= ARB_MASTER1;
      r_hold_cnt <= 4'd0;
    end else if (w_valid) begin
      r_state    <= w_grant ? ARB_G1 : ARB_G0;
      r_last     <= w_grant;
      r_hold_cnt <= (w_held && (w_grant == w_holder)) ? hold_next(r_hold_cnt) : 4'd1;
    end else begin
      r_state <= ARB_IDLE;
    end
  end

  // Reset gates the access combinationally so a mid-grant write never reaches the RAM.
  assign w_act0 = !rst && (r_state == ARB_G0) && m0_req;
  assign w_act1 = !rst && (r_state == ARB_G1) && m1_req;

  always_comb begin
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = 4'd0;
    ram_addr   = '0;
    ram_data_o = '0;
    if (w_act0) begin
      ram_ce     = 1'b1;
      ram_we     = m0_we;
      ram_sel    = m0_sel;
      ram_addr   = m0_addr;
      ram_data_o = m0_wdata;
    end else if (w_act1) begin
      ram_ce     = 1'b1;
      ram_we     = m1_we;
      ram_sel    = m1_sel;
      ram_addr   = m1_addr;
      ram_data_o = m1_wdata;
    end
  end

  assign m0_ack   = w_act0;
  assign m1_ack   = w_act1;
  assign m0_rdata = w_act0 ? ram_data_i : '0;
  assign m1_rdata = w_act1 ? ram_data_i : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_data_o, ram_data_i;

  logic [31:0] mem [0:63];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  int total = 0;
  int passed = 0;
  int acks;

  always #5 clk = ~clk;

  data_ram_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_sel(m0_sel), .m1_sel(m1_sel),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // RAM model: combinational read, clocked byte-enabled write
  assign ram_data_i = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
    m0_sel = 4'hF; m1_sel = 4'hF; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1; ld_en = 0; ld_idx = 0; ld_val = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    next_cycle();
    ld_en = 1; ld_idx = 6'd4; ld_val = 32'hDEAD_BEEF;
    next_cycle();
    ld_idx = 6'd8; ld_val = 32'h1111_1111;
    next_cycle();
    ld_en = 0;
    rst = 0;
    @(negedge clk);
    chk("reset_m0_ack", 32'(m0_ack), 0);
    chk("reset_m1_ack", 32'(m1_ack), 0);
    chk("reset_ram_ce", 32'(ram_ce), 0);
    chk("reset_state", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("reset_last", 32'(dut.r_last), 1);
    chk("reset_hold", 32'(dut.r_hold_cnt), 0);

    // single read of 0x10
    next_cycle();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    chk("read_ack_req_cycle", 32'(m0_ack), 0);
    next_cycle();
    @(negedge clk);
    chk("read_ack", 32'(m0_ack), 1);
    chk("read_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("read_ram_we", 32'(ram_we), 0);
    chk("read_ram_addr", ram_addr, 32'h10);
    chk("read_m1_rdata", m1_rdata, 0);
    next_cycle();
    m0_req = 0;
    next_cycle();

    // unlocked contention: strict alternation starting with master 0
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    m0_addr = 32'h40; m1_addr = 32'h44;
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      m0_wdata = 32'hA000_0000 + i;
      m1_wdata = 32'hB000_0000 + i;
      @(negedge clk);
      chk($sformatf("cont_m0_ack_%0d", i), 32'(m0_ack), 32'(i % 2));
      chk($sformatf("cont_m1_ack_%0d", i), 32'(m1_ack), 32'((i + 1) % 2));
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);
    chk("cont_mem_m0", mem[16], 32'hA000_0005);
    chk("cont_mem_m1", mem[17], 32'hB000_0006);

    // lock bound: m1 locked gets 4 grants, then m0 once, then m1
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h10;
    next_cycle();
    m0_req = 1; m0_addr = 32'h10;
    @(negedge clk);
    chk("lock_m1_ack_1", 32'(m1_ack), 1);
    for (int i = 2; i <= 6; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("lock_m0_ack_%0d", i), 32'(m0_ack), 32'(i == 5));
      chk($sformatf("lock_m1_ack_%0d", i), 32'(m1_ack), 32'(i != 5));
    end

    // lock without contention: no stall, hold counter saturates
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      @(negedge clk);
      acks += int'(m0_ack);
    end
    chk("solo_lock_acks", 32'(acks), 20);
    chk("solo_lock_hold_sat", 32'(dut.r_hold_cnt), 15);

    // withdrawal during m1 grant
    do_reset();
    m1_req = 1;
    next_cycle();
    m1_req = 0; m0_req = 1;
    @(negedge clk);
    chk("wd_ram_ce", 32'(ram_ce), 0);
    chk("wd_m1_ack", 32'(m1_ack), 0);
    chk("wd_m0_ack", 32'(m0_ack), 0);
    next_cycle();
    @(negedge clk);
    chk("wd_next_m0_ack", 32'(m0_ack), 1);
    chk("wd_next_state", 32'(dut.r_state), 32'(ARB_G0));

    // reset asserted mid-write must suppress the RAM write
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1234_5678;
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rstw_ram_we", 32'(ram_we), 0);
    chk("rstw_ram_ce", 32'(ram_ce), 0);
    chk("rstw_m0_ack", 32'(m0_ack), 0);
    next_cycle();
    rst = 0;
    clear_inputs();
    @(negedge clk);
    chk("rstw_mem_unchanged", mem[8], 32'h1111_1111);
    chk("rstw_state", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("rstw_ram_addr", ram_addr, 0);
    chk("rstw_ram_data_o", ram_data_o, 0);
    chk("rstw_last", 32'(dut.r_last), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
